hs_upload_reader: RTL
=====================

HS_UPLOAD_READER -- requirements
Module: hs_upload_reader

Interface
REQ-001 SHALL have parameter HS_ADDRESSWIDTH, default 16, the width of the game RAM address.
REQ-002 SHALL have parameter CFG_ENTRIES, default 8, the number of region table entries.
REQ-003 SHALL have parameter RAM_LATENCY, default 2, the number of clk_sys cycles from ram_address valid to data_from_ram valid.
REQ-004 SHALL have parameter UPLOAD_INDEX, default 4, the ioctl_index that selects this block.
REQ-005 Port clk_sys, input, 1: the single clock of the block.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port ioctl_download, input, 1: table load in progress.
REQ-008 Port ioctl_upload, input, 1: upload in progress.
REQ-009 Port ioctl_wr, input, 1: table byte strobe.
REQ-010 Port ioctl_rd, input, 1: upload byte consumed strobe.
REQ-011 Port ioctl_index, input, 8: transfer index.
REQ-012 Port ioctl_addr, input, 25: byte address.
REQ-013 Port ioctl_dout, input, 8: table data.
REQ-014 Port ioctl_din, output, 8: upload data.
REQ-015 Port ram_address, output, HS_ADDRESSWIDTH: game RAM read address.
REQ-016 Port ram_intent_read, output, 1: RAM access request.
REQ-017 Port data_from_ram, input, 8: RAM read data.
REQ-018 Port pause_cpu, output, 1: CPU halt request.
REQ-019 Port paused, input, 1: CPU halt acknowledge.
REQ-020 Port configured, output, 1: table holds at least one entry.

Function
REQ-021 Table load: each entry is 4 bytes (start hi, start lo, length-1 hi, length-1 lo), written when ioctl_download & ioctl_wr & ioctl_index==UPLOAD_INDEX; entry = ioctl_addr[..:2]; writes with entry >= CFG_ENTRIES are ignored.
REQ-022 configured SHALL be set on the first accepted table write and SHALL be cleared only by reset; entry count = highest written entry + 1.
REQ-023 FSM states: IDLE, PAUSE, FETCH, WAITDATA, HOLD, DONE.
REQ-024 IDLE->PAUSE on rising edge of ioctl_upload with ioctl_index==UPLOAD_INDEX and configured; pause_cpu=1 from the PAUSE state until DONE exits.
REQ-025 PAUSE->FETCH when paused==1; entry pointer=0, offset=0.
REQ-026 FETCH: ram_address=start+offset (modulo 2^HS_ADDRESSWIDTH), ram_intent_read=1 for exactly RAM_LATENCY cycles (WAITDATA), then data_from_ram is latched into ioctl_din -> HOLD.
REQ-027 HOLD: ioctl_din stable until ioctl_rd; on ioctl_rd, offset increments; offset==length-1 advances entry and clears offset; after the last entry -> DONE, else -> FETCH.
REQ-028 ioctl_rd received outside HOLD SHALL be ignored.
REQ-029 Falling ioctl_upload in any non-IDLE state -> DONE; DONE drops pause_cpu and returns to IDLE next cycle.
REQ-030 After DONE, ioctl_din SHALL read 8'h00.
REQ-031 Loss of paused during FETCH/WAITDATA SHALL return to PAUSE and restart the current byte.

Reset
REQ-032 Reset SHALL put the FSM in IDLE and SHALL set ioctl_din=0, ram_address=0, ram_intent_read=0, pause_cpu=0 and configured=0; the table contents are don't-care.
REQ-033 Reset mid-upload SHALL abort the upload with no further RAM access.

Configuration
REQ-034 With HS_UPLOAD_CHECKSUM_EN defined, one extra byte SHALL follow the last entry: the 8-bit two's-complement of the sum of all uploaded bytes, given in HOLD before DONE.
REQ-035 Without HS_UPLOAD_CHECKSUM_EN, the block SHALL have no accumulator and DONE SHALL follow the last data byte.

Structure
REQ-036 The FSM state enum and the entry-size constant (4) SHALL live in the shared package hs_pkg.
REQ-037 The region table SHALL be the sub-module hs_cfg_table: CFG_ENTRIES x 32-bit, one write port, one asynchronous read port.

Verification
REQ-038 Table {0x6100,len 3}, RAM 0x6100..=AA,BB,CC, upload with 3 rd strobes -> din AA, BB, CC, then DONE and pause_cpu=0.
REQ-039 Two entries {0x6000,len1},{0x6200,len2} -> reads at 0x6000, 0x6200, 0x6201 in that order.
REQ-040 paused is held low for 50 cycles -> no ram_intent_read until paused rises.
REQ-041 ioctl_upload drops after byte 1 of 3 -> DONE, pause_cpu=0 within 2 cycles.
REQ-042 Checksum build, bytes 01,02 -> extra byte FD.
REQ-043 Reset asserted in WAITDATA -> all outputs 0 on the next cycle, FSM in IDLE.

Source files
------------

// File: rtl/hs_pkg.sv
// hs_pkg: shared FSM state type and region-table entry geometry for the upload reader.
package hs_pkg;
    typedef enum logic [2:0] {IDLE, PAUSE, FETCH, WAITDATA, HOLD, DONE} state_t;
    localparam int ENTRY_BYTES = 4;
endpackage

// File: rtl/hs_cfg_table.sv
// hs_cfg_table: region table, one byte-lane write port and one asynchronous read port.
module hs_cfg_table #(
    parameter int ENTRIES = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wbyte,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [ENTRIES];

    // byte 0 of an entry is the most significant byte
    always_ff @(posedge clk)
        if (we) mem[waddr][{~wbyte, 3'b000} +: 8] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/hs_upload_reader.sv
// hs_upload_reader: streams game RAM regions listed in a loaded table out over ioctl upload.
// Define HS_UPLOAD_CHECKSUM_EN to append a two's-complement checksum byte after the last region.
module hs_upload_reader import hs_pkg::*; #(
    parameter int HS_ADDRESSWIDTH = 16,
    parameter int CFG_ENTRIES = 8,
    parameter int RAM_LATENCY = 2,
    parameter int UPLOAD_INDEX = 4
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       ioctl_download,
    input  logic                       ioctl_upload,
    input  logic                       ioctl_wr,
    input  logic                       ioctl_rd,
    input  logic [7:0]                 ioctl_index,
    input  logic [24:0]                ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    output logic [7:0]                 ioctl_din,
    output logic [HS_ADDRESSWIDTH-1:0] ram_address,
    output logic                       ram_intent_read,
    input  logic [7:0]                 data_from_ram,
    output logic                       pause_cpu,
    input  logic                       paused,
    output logic                       configured
);
    localparam int EW = CFG_ENTRIES > 1 ? $clog2(CFG_ENTRIES) : 1;
    localparam int CW = RAM_LATENCY > 1 ? $clog2(RAM_LATENCY) : 1;
    localparam int BW = $clog2(ENTRY_BYTES);

    state_t state;
    logic upload_q;
    logic [EW-1:0] last, ptr;
    logic [15:0] offset;
    logic [CW-1:0] cnt;
    logic [31:0] entry;
`ifdef HS_UPLOAD_CHECKSUM_EN
    logic [7:0] sum;
    logic csum;
`endif

    wire [EW-1:0] wentry = ioctl_addr[EW+BW-1:BW];
    wire wr_en = ioctl_download && ioctl_wr && ioctl_index == 8'(UPLOAD_INDEX) &&
                 (ioctl_addr >> BW) < 25'(CFG_ENTRIES);
    wire [HS_ADDRESSWIDTH-1:0] ram_next = HS_ADDRESSWIDTH'(32'(entry[31:16]) + 32'(offset));
    wire last_byte = offset == entry[15:0];
    wire last_entry = ptr == last;

    hs_cfg_table #(.ENTRIES(CFG_ENTRIES), .AW(EW)) u_table (
        .clk(clk_sys), .we(wr_en), .waddr(wentry), .wbyte(ioctl_addr[1:0]),
        .wdata(ioctl_dout), .raddr(ptr), .rdata(entry)
    );

    always_ff @(posedge clk_sys) begin
        upload_q <= ioctl_upload;
        if (reset) begin
            configured <= 1'b0;
            last <= '0;
        end else if (wr_en) begin
            configured <= 1'b1;
            if (!configured || wentry > last) last <= wentry;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            ioctl_din <= '0;
            ram_address <= '0;
            ram_intent_read <= 1'b0;
            pause_cpu <= 1'b0;
            ptr <= '0;
            offset <= '0;
            cnt <= '0;
`ifdef HS_UPLOAD_CHECKSUM_EN
            sum <= '0;
            csum <= 1'b0;
`endif
        end else if (state != IDLE && state != DONE && !ioctl_upload) begin
            state <= DONE;
            ram_intent_read <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (ioctl_upload && !upload_q && ioctl_index == 8'(UPLOAD_INDEX) && configured) begin
                        state <= PAUSE;
                        pause_cpu <= 1'b1;
                        ptr <= '0;
                        offset <= '0;
`ifdef HS_UPLOAD_CHECKSUM_EN
                        sum <= '0;
                        csum <= 1'b0;
`endif
                    end
                PAUSE:
                    if (paused) state <= FETCH;
                FETCH:
                    if (!paused) state <= PAUSE;
                    else begin
                        ram_address <= ram_next;
                        ram_intent_read <= 1'b1;
                        cnt <= '0;
                        state <= WAITDATA;
                    end
                WAITDATA:
                    // losing the halt mid-read restarts the same byte from PAUSE
                    if (!paused) begin
                        state <= PAUSE;
                        ram_intent_read <= 1'b0;
                    end else if (cnt == CW'(RAM_LATENCY - 1)) begin
                        ram_intent_read <= 1'b0;
                        ioctl_din <= data_from_ram;
`ifdef HS_UPLOAD_CHECKSUM_EN
                        sum <= sum + data_from_ram;
`endif
                        state <= HOLD;
                    end else cnt <= cnt + 1'b1;
                HOLD:
                    if (ioctl_rd) begin
`ifdef HS_UPLOAD_CHECKSUM_EN
                        if (csum) state <= DONE; else
`endif
                        if (!last_byte) begin
                            offset <= offset + 16'd1;
                            state <= FETCH;
                        end else if (!last_entry) begin
                            ptr <= ptr + 1'b1;
                            offset <= '0;
                            state <= FETCH;
                        end else begin
`ifdef HS_UPLOAD_CHECKSUM_EN
                            csum <= 1'b1;
                            ioctl_din <= 8'd0 - sum;
`else
                            state <= DONE;
`endif
                        end
                    end
                DONE: begin
                    pause_cpu <= 1'b0;
                    ioctl_din <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
